// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants, types and elaboration-time table builders for seq_detect_param
// Contents:
//   SEQ_MAX_W       : widest supported pattern
//   seq_out_mode_e  : output timing mode label (MEALY / MOORE)
//   pat_bit()       : pattern bit in arrival order
//   border_len()    : longest proper prefix of the pattern that is also a suffix
//   seq_next()      : KMP next state for a given matched count and incoming bit
package seq_det_pkg;

  localparam int SEQ_MAX_W = 16;

  typedef enum {MEALY, MOORE} seq_out_mode_e;

  // j = 0 is the first bit received, which lives at pattern[len-1].
  function automatic logic pat_bit(input logic [SEQ_MAX_W-1:0] pattern, input int len, input int j);
    logic [SEQ_MAX_W-1:0] t;
    t = pattern >> (len - 1 - j);
    return t[0];
  endfunction

  function automatic int border_len(input logic [SEQ_MAX_W-1:0] pattern, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < SEQ_MAX_W; k++) begin
      if (k < len) begin
        ok = 1'b1;
        for (int i = 0; i < SEQ_MAX_W; i++) begin
          if (i < k) begin
            if (pat_bit(pattern, len, i) != pat_bit(pattern, len, len - k + i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // With st bits matched, the received tail is pattern bits 0..st-1 followed by b.
  // A completing bit at st = len-1 yields the overlap restart point border_len().
  function automatic int seq_next(input logic [SEQ_MAX_W-1:0] pattern, input int len,
                                  input int st, input logic b);
    int   res;
    logic ok;
    logic r;
    res = 0;
    if (b == pat_bit(pattern, len, st)) begin
      res = (st < len - 1) ? st + 1 : border_len(pattern, len);
    end else begin
      for (int k = 1; k < SEQ_MAX_W; k++) begin
        if (k <= st) begin
          ok = 1'b1;
          for (int i = 0; i < SEQ_MAX_W; i++) begin
            if (i < k) begin
              if (st + 1 - k + i == st) r = b;
              else r = pat_bit(pattern, len, st + 1 - k + i);
              if (r != pat_bit(pattern, len, i)) ok = 1'b0;
            end
          end
          if (ok) res = k;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with synchronous clear
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   inc       : count one match
//   clr       : synchronous clear, dominates inc
//   cnt       : current count, stops at all-ones
//   sat       : high while cnt is all-ones
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt = r_cnt;
  assign sat = (r_cnt == '1);

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial pattern detector with saturating match counter
// Macro: SEQ_DET_MEALY_EN selects combinational (Mealy) out; undefined gives registered (Moore) out.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   in_valid   : qualifies in; when low the detector holds
//   in         : serial data bit, PATTERN[PAT_W-1] expected first
//   clr_cnt    : synchronous clear of match_cnt
//   out        : match indication
//   match_cnt  : saturating number of matches
//   cnt_sat    : match_cnt is all-ones
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter     PATTERN = 4'b1010,
  parameter bit OVERLAP = 1'b0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clr_cnt,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int ST_W = $clog2(PAT_W + 1);
  localparam int ST_N = 1 << ST_W;
  localparam logic [SEQ_MAX_W-1:0] PAT_EXT = SEQ_MAX_W'(PATTERN);
  localparam int BORDER = border_len(PAT_EXT, PAT_W);

  if (PAT_W < 2 || PAT_W > SEQ_MAX_W) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W=%0d outside 2..%0d", PAT_W, SEQ_MAX_W);
  end
  if ($bits(PATTERN) != PAT_W) begin : g_bad_pattern
    $error("seq_detect_param: PATTERN is %0d bits, PAT_W is %0d", $bits(PATTERN), PAT_W);
  end

  // Next-state tables for each incoming bit value; unreachable codes park at 0.
  logic [ST_W-1:0] w_nxt0 [ST_N];
  logic [ST_W-1:0] w_nxt1 [ST_N];

  for (genvar s = 0; s < ST_N; s++) begin : g_tbl
    localparam int NXT0 = (s < PAT_W) ? seq_next(PAT_EXT, PAT_W, s, 1'b0) : 0;
    localparam int NXT1 = (s < PAT_W) ? seq_next(PAT_EXT, PAT_W, s, 1'b1) : 0;
    assign w_nxt0[s] = ST_W'(NXT0);
    assign w_nxt1[s] = ST_W'(NXT1);
  end

  logic [ST_W-1:0] r_st;
  logic [ST_W-1:0] w_st_nxt;
  logic            w_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_st <= '0;
    else       r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = r_st;
    if (in_valid) begin
      if (w_hit)   w_st_nxt = OVERLAP ? ST_W'(BORDER) : '0;
      else if (in) w_st_nxt = w_nxt1[r_st];
      else         w_st_nxt = w_nxt0[r_st];
    end
  end

  // Last pattern bit expected is PATTERN[0].
  always_comb begin
    w_hit = in_valid && (r_st == ST_W'(PAT_W - 1)) && (in == PAT_EXT[0]);
  end

`ifdef SEQ_DET_MEALY_EN
  assign out = w_hit;
`else
  logic r_out;

  // Held across in_valid gaps so a pulse is not cut short by a stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_out <= 1'b0;
    else if (in_valid) r_out <= w_hit;
  end

  assign out = r_out;
`endif

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (w_hit),
    .clr  (clr_cnt),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - randomized and directed bench for seq_detect_param against a window-match model
module tb_seq_detect_param;
  import seq_det_pkg::*;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rstn;
  logic in_valid;
  logic din;
  logic clr_cnt;

  logic       outs [N];
  logic       sats [N];
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic [2:0] cnt3;
  logic [3:0] cnt4;

  int n_cmp = 0;
  int n_err = 0;

  int          m_w    [N];
  int          m_ovl  [N];
  int          m_cw   [N];
  logic [15:0] m_pat  [N];
  logic [15:0] m_hist [N];
  int          m_since[N];
  int          m_cnt  [N];
  bit          m_out  [N];
  bit          m_hit  [N];

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
    .out(outs[0]), .match_cnt(cnt0), .cnt_sat(sats[0]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .CNT_W(8)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
    .out(outs[1]), .match_cnt(cnt1), .cnt_sat(sats[1]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
    .out(outs[2]), .match_cnt(cnt2), .cnt_sat(sats[2]));
  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(3)) u3 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
    .out(outs[3]), .match_cnt(cnt3), .cnt_sat(sats[3]));
  seq_detect_param #(.PAT_W(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .CNT_W(4)) u4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in(din), .clr_cnt(clr_cnt),
    .out(outs[4]), .match_cnt(cnt4), .cnt_sat(sats[4]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_cnt(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      2:       return 32'(cnt2);
      3:       return 32'(cnt3);
      default: return 32'(cnt4);
    endcase
  endfunction

  // A match is the last PAT_W valid bits equalling the pattern, provided those bits
  // all arrived since reset and, without overlap, since the previous match.
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hist[i]  = '0;
      m_since[i] = 0;
      m_cnt[i]   = 0;
      m_out[i]   = 1'b0;
    end
  endtask

  task automatic check_outputs(input string pfx);
    for (int i = 0; i < N; i++) begin
`ifndef SEQ_DET_MEALY_EN
      check_eq($sformatf("%s.u%0d.out", pfx, i), 32'(outs[i]), 32'(m_out[i]));
`endif
      check_eq($sformatf("%s.u%0d.cnt", pfx, i), obs_cnt(i), 32'(m_cnt[i]));
      check_eq($sformatf("%s.u%0d.sat", pfx, i), 32'(sats[i]),
               32'(m_cnt[i] == (1 << m_cw[i]) - 1));
    end
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    logic [15:0] nh;
    logic [15:0] mask;
    @(negedge clk);
    in_valid = v;
    din      = b;
    clr_cnt  = c;
    for (int i = 0; i < N; i++) begin
      nh       = {m_hist[i][14:0], b};
      mask     = 16'((32'd1 << m_w[i]) - 1);
      m_hit[i] = v && (m_since[i] + 1 >= m_w[i]) && ((nh & mask) == m_pat[i]);
    end
    #1;
`ifdef SEQ_DET_MEALY_EN
    for (int i = 0; i < N; i++)
      check_eq($sformatf("mealy.u%0d.out", i), 32'(outs[i]), 32'(m_hit[i]));
`endif
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (v) begin
        m_hist[i] = {m_hist[i][14:0], b};
        if (m_hit[i] && m_ovl[i] == 0) m_since[i] = 0;
        else if (m_since[i] < 1000)    m_since[i]++;
        m_out[i] = m_hit[i];
      end
      if (c)                                          m_cnt[i] = 0;
      else if (m_hit[i] && m_cnt[i] < (1 << m_cw[i]) - 1) m_cnt[i]++;
    end
    #1;
    check_outputs("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn     = 1'b0;
    in_valid = 1'b0;
    din      = 1'b0;
    clr_cnt  = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("rst.u%0d.out", i), 32'(outs[i]), 32'd0);
      check_eq($sformatf("rst.u%0d.cnt", i), obs_cnt(i), 32'd0);
      check_eq($sformatf("rst.u%0d.sat", i), 32'(sats[i]), 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0);
  endtask

  initial begin
    seq_out_mode_e mode;
`ifdef SEQ_DET_MEALY_EN
    mode = MEALY;
`else
    mode = MOORE;
`endif
    $display("seq_detect_param bench, output mode %s", mode.name());

    m_w   = '{4, 4, 4, 4, 6};
    m_ovl = '{0, 1, 1, 0, 1};
    m_cw  = '{8, 8, 2, 3, 4};
    m_pat = '{16'b1010, 16'b1010, 16'b1101, 16'b1101, 16'b110110};
    rstn = 1'b1; in_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    model_reset();

    // 1,0,1,0,1,0,1,0 on 1010: two matches without overlap, three with.
    do_reset();
    send_bits(16'b10101010, 8);
    check_eq("tp1.nonovl.cnt", obs_cnt(0), 32'd2);
    check_eq("tp1.ovl.cnt", obs_cnt(1), 32'd3);

    // 1,1,0,1,1,0,1 on 1101: bits 4 and 7 with overlap, bit 4 only without.
    do_reset();
    send_bits(16'b1101101, 7);
    check_eq("tp2.ovl.cnt", obs_cnt(2), 32'd2);
    check_eq("tp2.nonovl.cnt", obs_cnt(3), 32'd1);

    // Valid gaps in mid-pattern and right after a match.
    do_reset();
    send_bits(16'b10, 2);
    for (int k = 0; k < 5; k++) step(1'b0, k[0], 1'b0);
    send_bits(16'b10, 2);
    for (int k = 0; k < 3; k++) step(1'b0, ~k[0], 1'b0);
    check_eq("gap.cnt", obs_cnt(0), 32'd1);

    // Reset mid-pattern discards the partial match.
    do_reset();
    send_bits(16'b101, 3);
    do_reset();
    send_bits(16'b01010, 5);
    check_eq("midrst.cnt", obs_cnt(0), 32'd1);

    // Five overlapping 1101 matches saturate a 2-bit counter; clear beats a coincident hit.
    do_reset();
    send_bits(16'b1101101101101101, 16);
    check_eq("sat.cnt", obs_cnt(2), 32'd3);
    check_eq("sat.flag", 32'(sats[2]), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_eq("clrhit.cnt", obs_cnt(2), 32'd0);

    // Random traffic with stalls, clears and occasional resets.
    do_reset();
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 99) < 80, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial pattern detector: the successor to the fixed 1010 detectors. It compares a 1-bit input stream against a compile-time pattern of configurable length and value. Each detection raises `out`, and a saturating match counter increments. Overlapping or non-overlapping detection is chosen by parameter, and Mealy or Moore output timing is chosen by macro. It sits in the Sequence Detectors group as the general block that the fixed-pattern variants reduce to.

## Interface
- `PAT_W`, default 4: pattern length in bits, legal range 2..16.
- `PATTERN`, default 4'b1010: pattern value, `PAT_W` bits wide. `PATTERN[PAT_W-1]` is the first bit received.
- `OVERLAP`, default 0: 1 selects overlapping detection, 0 selects non-overlapping.
- `CNT_W`, default 8: width of the match counter.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: qualifies `in`. When low, the bit is ignored and the state is held.
- `in`, input, 1: serial data bit.
- `clr_cnt`, input, 1: synchronous clear of `match_cnt`.
- `out`, output, 1: match indication.
- `match_cnt`, output, `CNT_W`: number of matches, saturating.
- `cnt_sat`, output, 1: high while `match_cnt` equals 2^`CNT_W`-1.

## Operation
- State `st` counts pattern bits matched so far, range 0..`PAT_W`-1. Width is $clog2(`PAT_W`+1).
- On a valid bit, the expected bit is `PATTERN[PAT_W-1-st]`.
  - If `in` equals the expected bit and `st` is below `PAT_W`-1: `st` goes to `st`+1.
  - If `in` equals the expected bit and `st` equals `PAT_W`-1: this is a match (`hit`).
  - If `in` differs: use KMP failure transitions. `st` goes to the longest `k` that is at most `st` such that the last `k` bits received equal the first `k` pattern bits.
- Failure and next-state tables are computed at elaboration from `PATTERN`. They are never hard-coded.
- On `hit`:
  - `OVERLAP`=1: `st` goes to border(`PAT_W`), the longest proper prefix of the pattern that is also a suffix.
  - `OVERLAP`=0: `st` goes to 0.
- When `in_valid` is low:
  - `st`, `match_cnt` and the Moore `out` register hold.
  - `hit` is forced to 0.
- `match_cnt`:
  - Increments by 1 on each `hit`.
  - Saturates at 2^`CNT_W`-1 and never wraps.
  - If `clr_cnt` and `hit` occur in the same cycle, the result is 0; clear wins.
- Reset values: `st`=0, `out`=0, `match_cnt`=0, `cnt_sat`=0.
- An illegal `PAT_W`, or a `PATTERN` width mismatch, raises an elaboration-time `$error`.

## Timing
- Mealy (see Configuration):
  - `out` = `hit`, combinational from `in`, `in_valid` and `st`.
  - `out` is high during the cycle in which the final pattern bit is presented.
- Moore (default):
  - `out` is registered and goes high for exactly one cycle, starting at the clock edge that samples the final bit.
  - Latency is 1 cycle relative to Mealy.
  - If `in_valid` is low in the following cycle, `out` is held rather than cleared.
- `match_cnt` updates at the same edge that samples the final bit, in both modes.
- `cnt_sat` is combinational from `match_cnt`.
- When `rstn` is asserted mid-pattern:
  - All state clears immediately, asynchronously.
  - A partial match is discarded.
  - Detection restarts from `st`=0 on the first valid bit after deassertion.
- Back-to-back matches are supported every `PAT_W`-border cycles in overlap mode, and every `PAT_W` cycles in non-overlap mode.

## Configuration
- `SEQ_DET_MEALY_EN` defined: Mealy output; `out` is combinational and has no extra register.
- `SEQ_DET_MEALY_EN` undefined: Moore output; `out` comes from a registered `hit`, 1 cycle later.
- `st`, the counter and the tables are identical in both builds.

## Structure
- Package `seq_det_pkg` contains:
  - the elaboration function `border_len(pattern, len)`;
  - the next-state function `seq_next(pattern, len, st, bit)`;
  - constant `SEQ_MAX_W`=16;
  - `typedef enum {MEALY, MOORE} seq_out_mode_e`, used by benches for reporting.
- Sub-module `seq_match_counter`:
  - parameter `CNT_W`;
  - inputs `clk`, `rstn`, `inc`, `clr`;
  - outputs `cnt`, `sat`;
  - implements the saturating counter.
- The top level holds `st`, the detection logic and the output register.

## Test plan
- Default build: `PAT_W`=4, `PATTERN`=1010, `OVERLAP`=0, Moore.
  - Stream 1,0,1,0,1,0,1,0 gives `out` pulses after bits 4 and 8, and `match_cnt`=2.
- Same stream with `OVERLAP`=1 gives pulses after bits 4, 6 and 8, and `match_cnt`=3.
- `PATTERN`=1101 with `OVERLAP`=1:
  - Stream 1,1,0,1,1,0,1 gives hits at bits 4 and 7.
  - With `OVERLAP`=0, the same stream gives a hit at bit 4 only.
- `in_valid` gaps: send 1,0, hold `in_valid`=0 for 5 cycles with `in` toggling, then send 1,0.
  - Required: exactly one hit.
  - Required: `out` and `st` are unchanged during the gap.
- Reset mid-pattern: send 1,0,1, assert `rstn`=0 for 1 cycle, then send 0,1,0,1,0.
  - Required: no hit on the first 0 after release; one hit at the final 0.
  - Required: all outputs are 0 while in reset.
- Counter edge cases with `CNT_W`=2:
  - 5 matches give `match_cnt`=3 and `cnt_sat`=1.
  - `clr_cnt` coincident with a hit gives `match_cnt`=0.
- `SEQ_DET_MEALY_EN` build with the first stream: `out` is high in the same cycle as bits 4 and 8, one cycle earlier than in the Moore build.
